mips_mem_arbiter: RTL

- Parametrised memory front-end between the pipelined MIPS core's split instruction/data ports and one unified, variable-latency memory with a request/grant/response handshake.
- Arbitrates the two ports, generates per-port stall signals for the pipeline and returns read data.
- Bounds every access with a wait-state timeout.
- Instantiated inside the core wrapper, between the CPU core and the unified memory/bus.

---
 rtl/mips_mem_pkg.sv | 22 ++
 rtl/mips_arb_pick.sv | 41 ++++
 rtl/mips_mem_arbiter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS memory arbiter: FSM state
// encoding, port ownership, and the default read data returned when an
// access times out.
package mips_mem_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_e;

    // Which CPU port currently owns (or last owned) the memory.
    typedef enum logic {
        INST = 1'b0,
        DATA = 1'b1
    } owner_e;

    // Read data handed back to the core when memory never responds.
    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage : mips_mem_pkg

// File: rtl/mips_arb_pick.sv
// Combinational grant selector for the MIPS memory arbiter.
// Default build: fixed priority, the data port wins when both ports request.
// With MIPS_ARB_FAIR_EN defined: round robin between the two ports, the port
// that did not own the previous access wins a simultaneous request.
module mips_arb_pick
    import mips_mem_pkg::*;
(
    input  logic   i_req,
    input  logic   d_req,
    input  owner_e last_owner,
    output logic   gnt_valid,
    output owner_e gnt_owner
);

`ifndef MIPS_ARB_FAIR_EN
    // The history is kept by the top in every build; only the fair build
    // reads it.
    logic last_owner_unused;
    assign last_owner_unused = last_owner;
`endif

    // Select which port gets the memory when the arbiter is free.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves a value
        // unassigned and no latch is inferred.
        gnt_valid = i_req || d_req;
        gnt_owner = DATA;
`ifdef MIPS_ARB_FAIR_EN
        if (i_req && d_req) begin
            gnt_owner = (last_owner == DATA) ? INST : DATA;
        end else if (i_req) begin
            gnt_owner = INST;
        end
`else
        if (i_req && !d_req) begin
            gnt_owner = INST;
        end
`endif
    end

endmodule : mips_arb_pick

// File: rtl/mips_mem_arbiter.sv
// Memory front-end between the MIPS core's split instruction/data ports and
// one unified, variable-latency memory (req/gnt then rvalid handshake).
// One access is in flight at a time: IDLE picks a port and registers its
// fields, REQ holds the request until mem_gnt, WAIT collects mem_rvalid or
// forces completion after TIMEOUT cycles with ERR_DATA and a sticky bus_err.
// Optional build macro: MIPS_ARB_FAIR_EN (round-robin arbitration, see
// mips_arb_pick); left undefined the data port has fixed priority.
module mips_mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int          ADDR_W   = 32,
    parameter int          DATA_W   = 32,   // multiple of 8
    parameter int          TIMEOUT  = 255,  // at least 1
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,        // asynchronous, active low

    // Instruction port
    input  logic                i_ren,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_ready,
    output logic                i_stall,

    // Data port
    input  logic                d_ren,
    input  logic                d_wen,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ready,
    output logic                d_stall,

    // Unified memory
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,

    output logic                bus_err
);

    localparam int                BE_W     = DATA_W / 8;
    localparam int                CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT);
    localparam logic [DATA_W-1:0] ERR_WORD = DATA_W'(ERR_DATA);

    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    owner_e            last_owner_q, last_owner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [BE_W-1:0]   mem_be_q, mem_be_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              bus_err_q, bus_err_d;

    logic              d_req;
    logic              pick_valid;
    owner_e            pick_owner;
    logic              rsp_hit;
    logic              timeout_hit;
    logic              access_done;
    logic [DATA_W-1:0] rsp_data;

    assign d_req = d_ren || d_wen;

    mips_arb_pick u_pick (
        .i_req      (i_ren),
        .d_req      (d_req),
        .last_owner (last_owner_q),
        .gnt_valid  (pick_valid),
        .gnt_owner  (pick_owner)
    );

    // A response always wins over a timeout landing in the same cycle.
    assign rsp_hit     = (state_q == WAIT) && mem_rvalid;
    assign timeout_hit = (state_q == WAIT) && !mem_rvalid && (cnt_q == CNT_LAST);
    assign access_done = rsp_hit || timeout_hit;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            // NOTE: flops update with <= so every always_ff reads the values
            // from before the edge, independent of block ordering.
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pick_valid)  state_d = REQ;
            REQ:     if (mem_gnt)     state_d = WAIT;
            WAIT:    if (access_done) state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    // Datapath registers: captured request fields, ownership, wait counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: an abandoned access must not leave a stale request on
            // the bus, so every registered memory output resets to zero.
            owner_q      <= DATA;
            last_owner_q <= DATA;
            cnt_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            bus_err_q    <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            bus_err_q    <= bus_err_d;
        end
    end

    // Datapath next values: launch in IDLE, drop req on grant, count in WAIT.
    always_comb begin
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_be_d     = mem_be_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        bus_err_d    = bus_err_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d   = pick_owner;
                    mem_req_d = 1'b1;
                    if (pick_owner == DATA) begin
                        mem_we_d    = d_wen;
                        mem_be_d    = d_wen ? d_be : '1;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wen ? d_wdata : '0;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_be_d    = '1;
                        mem_addr_d  = i_addr;
                        mem_wdata_d = '0;
                    end
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    cnt_d     = '0;
                end
            end
            WAIT: begin
                if (access_done) begin
                    last_owner_d = owner_q;
                    if (timeout_hit) begin
                        bus_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Completion outputs: only the owning port sees ready and data.
    always_comb begin
        i_ready  = 1'b0;
        d_ready  = 1'b0;
        i_rdata  = '0;
        d_rdata  = '0;
        rsp_data = '0;
        if (access_done) begin
            if (timeout_hit) begin
                rsp_data = ERR_WORD;
            end else if (!mem_we_q) begin
                rsp_data = mem_rdata;
            end
            if (owner_q == INST) begin
                i_ready = 1'b1;
                i_rdata = rsp_data;
            end else begin
                d_ready = 1'b1;
                d_rdata = rsp_data;
            end
        end
    end

    assign i_stall   = i_ren && !i_ready;
    assign d_stall   = d_req && !d_ready;

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign bus_err   = bus_err_q;

endmodule : mips_mem_arbiter
